// File: rtl/iss_wide_pkg.sv
// Shared pipeline types for the issue stage: decoded instruction, IQ entry,
// ROB write record, branch condition codes and branch-stage state encoding.
package pipTypes;

    // Width of the ROB slot field carried in every IQ entry; ROB_IDX_W of the
    // issue stage must not exceed it.
    localparam int ROB_SLOT_W = 4;

    typedef enum logic [2:0] {
        COND_EQ = 3'd0,
        COND_NE = 3'd1,
        COND_GT = 3'd2,
        COND_GE = 3'd3,
        COND_LT = 3'd4,
        COND_LE = 3'd5,
        COND_AL = 3'd6
    } cond_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LS     = 3'd1,
        CLS_MUL    = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4
    } iclass_t;

    typedef struct packed {
        iclass_t     iclass;
        cond_t       cond;
        logic        rformat;
        logic [3:0]  op;
        logic [4:0]  dest_reg;
        logic        dest_reg_valid;
        logic [31:0] pc;
        logic [31:0] target;
    } dec_inst_t;

    typedef struct packed {
        dec_inst_t              inst;
        logic [ROB_SLOT_W-1:0]  slot;
    } iq_entry_t;

    typedef struct packed {
        logic [31:0] result_lo;
        logic [31:0] pc;
        logic        pc_valid;
        logic [4:0]  dest_reg;
        logic        dest_reg_valid;
    } rob_entry_t;

    typedef enum logic [1:0] {
        ISS_BR_IDLE    = 2'd0,
        ISS_BR_RESOLVE = 2'd1,
        ISS_BR_HOLD    = 2'd2
    } iss_br_state_t;

    // Branch condition on signed operands; COND_AL is unconditional.
    function automatic logic cond_true(input cond_t c, input logic [31:0] a,
                                       input logic [31:0] b);
        logic r;
        r = 1'b0;
        case (c)
            COND_EQ: r = (a == b);
            COND_NE: r = (a != b);
            COND_GT: r = ($signed(a) >  $signed(b));
            COND_GE: r = ($signed(a) >= $signed(b));
            COND_LT: r = ($signed(a) <  $signed(b));
            COND_LE: r = ($signed(a) <= $signed(b));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/iss_wide_disp.sv
// One registered, back-pressured dispatch port.
// Handshake: the held entry transfers on a cycle where valid=1 and ready=1;
// the register is free (may load) when empty or transferring this cycle.
module iss_disp_reg
    import pipTypes::*;
#(
    parameter int SLOT_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              ready,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic [31:0]       in_A,
    input  logic [31:0]       in_B,
    input  dec_inst_t         in_inst,
    output logic              free,
    output logic              valid,
    output logic [SLOT_W-1:0] slot,
    output logic [31:0]       A,
    output logic [31:0]       B,
    output dec_inst_t         inst
);

    logic              valid_q, valid_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    dec_inst_t         inst_q, inst_d;

    // Load wins; otherwise a transfer empties the register; otherwise hold.
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        a_d     = a_q;
        b_d     = b_q;
        inst_d  = inst_q;
        if (load) begin
            valid_d = 1'b1;
            slot_d  = in_slot;
            a_d     = in_A;
            b_d     = in_B;
            inst_d  = in_inst;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    // Payload and valid registers, cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
            a_q     <= a_d;
            b_q     <= b_d;
            inst_q  <= inst_d;
        end
    end

    assign free  = !valid_q || ready;
    assign valid = valid_q;
    assign slot  = slot_q;
    assign A     = a_q;
    assign B     = b_q;
    assign inst  = inst_q;

endmodule

// File: rtl/iss_wide.sv
// In-order wide issue stage: scans WIDTH IQ heads, dispatches the longest
// placeable in-order prefix to LS / MUL / NUM_ALU ALU ports, and resolves
// branches (redirect PC + link write to the ROB).
// Optional feature macro: ISS_ALU_ON_MUL_EN (ALU ops overflow onto MUL).
module iss_wide
    import pipTypes::*;
#(
    parameter int WIDTH     = 4,
    parameter int NUM_ALU   = 2,
    parameter int ROB_IDX_W = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iq_valid     [WIDTH],
    input  iq_entry_t                    iq_entry     [WIDTH],
    input  logic [31:0]                  iq_A         [WIDTH],
    input  logic [31:0]                  iq_B         [WIDTH],
    input  logic                         iq_ops_ready [WIDTH],
    output logic [$clog2(WIDTH+1)-1:0]   iq_consumed,
    output logic                         ls_valid,
    input  logic                         ls_ready,
    output logic [ROB_IDX_W-1:0]         ls_slot,
    output logic [31:0]                  ls_A,
    output logic [31:0]                  ls_B,
    output dec_inst_t                    ls_inst,
    output logic                         mul_valid,
    input  logic                         mul_ready,
    output logic [ROB_IDX_W-1:0]         mul_slot,
    output logic [31:0]                  mul_A,
    output logic [31:0]                  mul_B,
    output dec_inst_t                    mul_inst,
    output logic                         alu_valid    [NUM_ALU],
    input  logic                         alu_ready    [NUM_ALU],
    output logic [ROB_IDX_W-1:0]         alu_slot     [NUM_ALU],
    output logic [31:0]                  alu_A        [NUM_ALU],
    output logic [31:0]                  alu_B        [NUM_ALU],
    output dec_inst_t                    alu_inst     [NUM_ALU],
    input  logic                         branch_stall,
    output logic [31:0]                  new_pc,
    output logic                         new_pc_valid,
    output logic                         wr_valid,
    output logic [ROB_IDX_W-1:0]         wr_slot,
    output rob_entry_t                   wr_data,
    output iss_br_state_t                br_state_dbg
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH+1);

    // Placement decisions of the current cycle.
    logic             ls_free, mul_free;
    logic             alu_free [NUM_ALU];
    logic             ls_load, mul_load, br_take;
    logic             alu_load [NUM_ALU];
    logic [IDX_W-1:0] ls_sel, mul_sel, br_sel;
    logic [IDX_W-1:0] alu_sel  [NUM_ALU];
    logic             next_valid [WIDTH];
    logic             stop;
    logic [CNT_W-1:0] count;

    // Branch stage held state.
    iss_br_state_t         br_state_q, br_state_d;
    logic [31:0]           br_pc_q, br_pc_d;
    logic [31:0]           br_target_q, br_target_d;
    logic [31:0]           br_a_q, br_a_d;
    logic [31:0]           br_b_q, br_b_d;
    cond_t                 br_cond_q, br_cond_d;
    logic                  br_rformat_q, br_rformat_d;
    logic                  br_jump_q, br_jump_d;
    logic [4:0]            br_dest_q, br_dest_d;
    logic                  br_dest_valid_q, br_dest_valid_d;
    logic [ROB_IDX_W-1:0]  br_slot_q, br_slot_d;

    // Delay-slot presence for each window position; the last has none.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) next_valid[i] = 1'b0;
        for (int i = 0; i < WIDTH - 1; i++) next_valid[i] = iq_valid[i+1];
    end

    // In-order scan: place each entry on its unit until the first miss.
    always_comb begin
        stop     = reset;
        count    = '0;
        ls_load  = 1'b0;
        ls_sel   = '0;
        mul_load = 1'b0;
        mul_sel  = '0;
        br_take  = 1'b0;
        br_sel   = '0;
        for (int a = 0; a < NUM_ALU; a++) begin
            alu_load[a] = 1'b0;
            alu_sel[a]  = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            logic placed;
            placed = 1'b0;
            if (!stop && iq_valid[i] && iq_ops_ready[i]) begin
                case (iq_entry[i].inst.iclass)
                    CLS_BRANCH, CLS_JUMP: begin
                        if (br_state_q == ISS_BR_IDLE && !br_take && next_valid[i]) begin
                            br_take = 1'b1;
                            br_sel  = i[IDX_W-1:0];
                            placed  = 1'b1;
                        end
                    end
                    CLS_LS: begin
                        if (ls_free && !ls_load) begin
                            ls_load = 1'b1;
                            ls_sel  = i[IDX_W-1:0];
                            placed  = 1'b1;
                        end
                    end
                    CLS_MUL: begin
                        if (mul_free && !mul_load) begin
                            mul_load = 1'b1;
                            mul_sel  = i[IDX_W-1:0];
                            placed   = 1'b1;
                        end
                    end
                    default: begin
                        for (int a = 0; a < NUM_ALU; a++) begin
                            if (!placed && alu_free[a] && !alu_load[a]) begin
                                alu_load[a] = 1'b1;
                                alu_sel[a]  = i[IDX_W-1:0];
                                placed      = 1'b1;
                            end
                        end
`ifdef ISS_ALU_ON_MUL_EN
                        if (!placed && mul_free && !mul_load) begin
                            mul_load = 1'b1;
                            mul_sel  = i[IDX_W-1:0];
                            placed   = 1'b1;
                        end
`endif
                    end
                endcase
            end
            if (placed) count = count + CNT_W'(1);
            else        stop  = 1'b1;
        end
    end

    assign iq_consumed = count;

    iss_disp_reg #(.SLOT_W(ROB_IDX_W)) u_ls (
        .clock   (clock),
        .reset   (reset),
        .load    (ls_load),
        .ready   (ls_ready),
        .in_slot (iq_entry[ls_sel].slot[ROB_IDX_W-1:0]),
        .in_A    (iq_A[ls_sel]),
        .in_B    (iq_B[ls_sel]),
        .in_inst (iq_entry[ls_sel].inst),
        .free    (ls_free),
        .valid   (ls_valid),
        .slot    (ls_slot),
        .A       (ls_A),
        .B       (ls_B),
        .inst    (ls_inst)
    );

    iss_disp_reg #(.SLOT_W(ROB_IDX_W)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load),
        .ready   (mul_ready),
        .in_slot (iq_entry[mul_sel].slot[ROB_IDX_W-1:0]),
        .in_A    (iq_A[mul_sel]),
        .in_B    (iq_B[mul_sel]),
        .in_inst (iq_entry[mul_sel].inst),
        .free    (mul_free),
        .valid   (mul_valid),
        .slot    (mul_slot),
        .A       (mul_A),
        .B       (mul_B),
        .inst    (mul_inst)
    );

    for (genvar g = 0; g < NUM_ALU; g++) begin : g_alu
        iss_disp_reg #(.SLOT_W(ROB_IDX_W)) u_alu (
            .clock   (clock),
            .reset   (reset),
            .load    (alu_load[g]),
            .ready   (alu_ready[g]),
            .in_slot (iq_entry[alu_sel[g]].slot[ROB_IDX_W-1:0]),
            .in_A    (iq_A[alu_sel[g]]),
            .in_B    (iq_B[alu_sel[g]]),
            .in_inst (iq_entry[alu_sel[g]].inst),
            .free    (alu_free[g]),
            .valid   (alu_valid[g]),
            .slot    (alu_slot[g]),
            .A       (alu_A[g]),
            .B       (alu_B[g]),
            .inst    (alu_inst[g])
        );
    end

    // Branch stage state and held operands; reset discards any held branch.
    always_ff @(posedge clock) begin
        if (reset) begin
            br_state_q      <= ISS_BR_IDLE;
            br_pc_q         <= '0;
            br_target_q     <= '0;
            br_a_q          <= '0;
            br_b_q          <= '0;
            br_cond_q       <= COND_EQ;
            br_rformat_q    <= 1'b0;
            br_jump_q       <= 1'b0;
            br_dest_q       <= '0;
            br_dest_valid_q <= 1'b0;
            br_slot_q       <= '0;
        end else begin
            br_state_q      <= br_state_d;
            br_pc_q         <= br_pc_d;
            br_target_q     <= br_target_d;
            br_a_q          <= br_a_d;
            br_b_q          <= br_b_d;
            br_cond_q       <= br_cond_d;
            br_rformat_q    <= br_rformat_d;
            br_jump_q       <= br_jump_d;
            br_dest_q       <= br_dest_d;
            br_dest_valid_q <= br_dest_valid_d;
            br_slot_q       <= br_slot_d;
        end
    end

    // Next state: accept only from IDLE; leave RESOLVE/HOLD when IF is free.
    always_comb begin
        br_state_d      = br_state_q;
        br_pc_d         = br_pc_q;
        br_target_d     = br_target_q;
        br_a_d          = br_a_q;
        br_b_d          = br_b_q;
        br_cond_d       = br_cond_q;
        br_rformat_d    = br_rformat_q;
        br_jump_d       = br_jump_q;
        br_dest_d       = br_dest_q;
        br_dest_valid_d = br_dest_valid_q;
        br_slot_d       = br_slot_q;
        case (br_state_q)
            ISS_BR_IDLE: begin
                if (br_take) begin
                    br_state_d      = ISS_BR_RESOLVE;
                    br_pc_d         = iq_entry[br_sel].inst.pc;
                    br_target_d     = iq_entry[br_sel].inst.target;
                    br_a_d          = iq_A[br_sel];
                    br_b_d          = iq_B[br_sel];
                    br_cond_d       = iq_entry[br_sel].inst.cond;
                    br_rformat_d    = iq_entry[br_sel].inst.rformat;
                    br_jump_d       = (iq_entry[br_sel].inst.iclass == CLS_JUMP);
                    br_dest_d       = iq_entry[br_sel].inst.dest_reg;
                    br_dest_valid_d = iq_entry[br_sel].inst.dest_reg_valid;
                    br_slot_d       = iq_entry[br_sel].slot[ROB_IDX_W-1:0];
                end
            end
            ISS_BR_RESOLVE: br_state_d = branch_stall ? ISS_BR_HOLD : ISS_BR_IDLE;
            ISS_BR_HOLD:    br_state_d = branch_stall ? ISS_BR_HOLD : ISS_BR_IDLE;
            default:        br_state_d = ISS_BR_IDLE;
        endcase
    end

    // Outputs: redirect driven while a branch is held, ROB write on release.
    always_comb begin
        new_pc       = '0;
        new_pc_valid = 1'b0;
        wr_valid     = 1'b0;
        wr_slot      = br_slot_q;
        wr_data      = '0;
        if (br_state_q == ISS_BR_RESOLVE || br_state_q == ISS_BR_HOLD) begin
            new_pc       = br_rformat_q ? br_a_q : br_target_q;
            new_pc_valid = br_jump_q || cond_true(br_cond_q, br_a_q, br_b_q);
            wr_valid     = !branch_stall;
            wr_data.result_lo      = br_pc_q + 32'd8;
            wr_data.pc             = new_pc;
            wr_data.pc_valid       = new_pc_valid;
            wr_data.dest_reg       = br_dest_q;
            wr_data.dest_reg_valid = br_dest_valid_q;
        end
    end

    assign br_state_dbg = br_state_q;

endmodule

// File: doc/iss_wide.md
# iss_wide

Parametrised in-order issue stage between the instruction queue and the execution units. Each cycle it scans a window of `WIDTH` queue heads and dispatches the longest in-order prefix whose operands are ready and whose target unit can accept. Dispatch goes into registered, back-pressured unit ports: one load/store, one mul/div and `NUM_ALU` ALUs. It also holds a branch-resolution stage that computes the redirect PC, retains the branch across IF stalls, and writes the link value to the ROB.

## Interface
Parameters:
- `WIDTH`, 4: IQ window size, ≥2.
- `NUM_ALU`, 2: number of ALU dispatch ports, ≥1.
- `ROB_IDX_W`, 4: ROB slot index width.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `iq_valid[WIDTH]` in 1: window entry valid.
- `iq_entry[WIDTH]` in `iq_entry_t`: decoded instruction plus ROB slot.
- `iq_A[WIDTH]`, `iq_B[WIDTH]` in 32: resolved operands.
- `iq_ops_ready[WIDTH]` in 1: all required operands valid.
- `iq_consumed` out $clog2(WIDTH+1): count of entries taken this cycle (0 = none).
- `ls_valid` out 1, `ls_ready` in 1, `ls_slot` out ROB_IDX_W, `ls_A`/`ls_B` out 32, `ls_inst` out `dec_inst_t`.
- `mul_valid`, `mul_ready`, `mul_slot`, `mul_A`, `mul_B`, `mul_inst`: same shape as the `ls_*` group.
- `alu_valid[NUM_ALU]`, `alu_ready[NUM_ALU]`, `alu_slot[NUM_ALU]`, `alu_A[NUM_ALU]`, `alu_B[NUM_ALU]`, `alu_inst[NUM_ALU]`: same shape, one group per ALU.
- `branch_stall` in 1: IF cannot take a redirect this cycle.
- `new_pc` out 32, `new_pc_valid` out 1: redirect request.
- `wr_valid` out 1, `wr_slot` out ROB_IDX_W, `wr_data` out `rob_entry_t`: branch result write to the ROB.

## Operation
- **Unit register free:** a unit's register is free when it is empty, or when it holds a valid entry and that unit's ready is high this cycle.
- **Scan:** entries are examined in order i = 0..WIDTH-1. The scan stops at the first entry that is invalid, not ops-ready, or unplaceable. `iq_consumed` = number placed.
- **Placement priority per entry:**
  - branch/jump → branch stage, if it is in IDLE and i < WIDTH-1 and `iq_valid[i+1]` (the delay-slot instruction must be present);
  - load/store → LS;
  - mul/div → MUL;
  - ALU → lowest-index free ALU not yet used this cycle.
- **One per unit:** each unit takes at most one instruction per cycle.
- **Dispatch registers:** a placed entry loads the unit's inst/A/B/slot and sets valid at the next edge. Valid clears when ready=1 and nothing new is loaded. The register holds unchanged while valid=1 and ready=0.
- **Branch FSM states:**
  - IDLE: the stage is empty.
  - RESOLVE: holds the branch for one cycle. Computes condition (EQ, NE, GT, GE, LT, LE, unconditional) from the held A/B. `new_pc` = held A if the instruction is rformat, else the branch target. `new_pc_valid` = jump, or branch with condition true.
    - If `branch_stall`=0: assert `wr_valid` and return to IDLE.
    - If `branch_stall`=1: go to HOLD.
  - HOLD: keeps all held values and keeps `new_pc`/`new_pc_valid` driven. On `branch_stall`=0: assert `wr_valid` and return to IDLE.
- **ROB write:** `wr_valid` is exactly one cycle per branch. `wr_data.result_lo` = pc+8. `dest_reg` and `dest_reg_valid` come from the held instruction. `pc_valid` = `new_pc_valid`.
- **Branch acceptance:** a new branch is accepted only in IDLE. No same-cycle IDLE bypass.
- **Reset:** all valids = 0; `iq_consumed` = 0; `new_pc_valid` = 0; `wr_valid` = 0; FSM = IDLE; data registers = 0. A reset during HOLD discards the branch.

## Timing
- `iq_consumed` is combinational in the same cycle as its inputs.
- Dispatch latency: 1 cycle from consumption to unit valid.
- Branch: consumed in cycle t → RESOLVE in t+1 → `new_pc_valid` and `wr_valid` in t+1 if there is no stall; otherwise on the first cycle with `branch_stall`=0.
- Back-pressure: full throughput of one instruction per unit per cycle while ready is held high.

## Configuration
- `ISS_ALU_ON_MUL_EN` defined: an ALU instruction that finds no free ALU is placed on MUL, if MUL is free and unused this cycle.
- `ISS_ALU_ON_MUL_EN` undefined: ALU instructions use ALU ports only, and the scan stops at that entry.

## Structure
- Shared package `pipTypes`: `iq_entry_t`, `dec_inst_t`, `rob_entry_t`, and the branch condition enum (`COND_*`).
- New package constant: `ISS_BR_IDLE/RESOLVE/HOLD` state encoding.
- Sub-module `iss_disp_reg`: one per unit. Holds the payload and valid, with load, ready and hold behaviour. Instantiated `NUM_ALU`+2 times.
- Branch FSM and placement scan live in the top.

## Test plan
- 4 valid ready ALU ops, NUM_ALU=2, all ready → `iq_consumed`=2; `alu_valid`=2'b11 next cycle; ops 0 and 1 on ALU0 and ALU1 respectively.
- Sequence LD, MUL, ALU, ALU with all ready → `iq_consumed`=4; LS, MUL, ALU0 and ALU1 all valid next cycle.
- `alu_ready[0]`=0 with ALU0 holding X → X is held unchanged; a new ALU op goes to ALU1 only.
- BEQ at i=0 with A=B=5, delay slot valid, `branch_stall`=0 → next cycle `new_pc_valid`=1, `new_pc`=target, `wr_valid`=1, `result_lo`=pc+8.
- Same branch with `branch_stall` high for 3 cycles → HOLD, `wr_valid`=0 during the stall, one `wr_valid` pulse on release; a second branch in the window is not consumed meanwhile.
- Branch at i=WIDTH-1 → not consumed; `iq_consumed` equals the count of entries before it. With `ISS_ALU_ON_MUL_EN`: 3 ALU ops, 2 ALUs → 3 consumed, third op on MUL.
